// File: rtl/demux4_stream_sched.sv
// 1:4 valid/ready stream demux with one registered entry per channel.
// Define DEMUX_RR_SKIP_EN to let round-robin skip channels that cannot accept.
module demux4_stream_sched #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [1:0]          s_dest,
  output logic [3:0]          m_valid,
  input  logic [3:0]          m_ready,
  output logic [4*DATA_W-1:0] m_data,
  output logic [1:0]          rr_ptr,
  output logic                busy
);

  logic [3:0]        r_valid;
  logic [DATA_W-1:0] r_data [4];
  logic [1:0]        r_rr;

  logic [3:0] w_can;
  logic [1:0] w_tgt;
  logic       w_rdy;
  logic       w_acc;

  // A full channel still accepts when its consumer drains this cycle
  assign w_can = ~r_valid | m_ready;

`ifdef DEMUX_RR_SKIP_EN
  always_comb begin
    w_tgt = s_dest;
    w_rdy = w_can[s_dest];
    if (mode) begin
      w_tgt = r_rr;
      w_rdy = 1'b0;
      // Descending scan so the nearest acceptor after r_rr wins
      for (int k = 3; k >= 0; k--) begin
        if (w_can[r_rr + 2'(k)]) begin
          w_tgt = r_rr + 2'(k);
          w_rdy = 1'b1;
        end
      end
    end
  end
`else
  assign w_tgt = mode ? r_rr : s_dest;
  assign w_rdy = w_can[w_tgt];
`endif

  assign w_acc = s_valid & w_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_rr    <= '0;
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc && (w_tgt == 2'(i))) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= s_data;
        end else if (m_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_acc && mode) begin
        r_rr <= w_tgt + 2'd1;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign m_data[g*DATA_W +: DATA_W] = r_data[g];
  end

  assign s_ready = w_rdy;
  assign m_valid = r_valid;
  assign rr_ptr  = r_rr;
  assign busy    = |r_valid;

endmodule

// File: tb/tb_demux4_stream_sched.sv
// Directed bench for demux4_stream_sched with immediate-assertion checks.
// Covers directed, round-robin, backpressure, drain+write and async reset.
module tb_demux4_stream_sched;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [1:0]  s_dest;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [31:0] m_data;
  logic [1:0]  rr_ptr;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  demux4_stream_sched #(.DATA_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_dest  (s_dest),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .rr_ptr  (rr_ptr),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] chd(input int c);
    return m_data[c*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] dst);
    s_valid = 1'b1;
    s_data  = d;
    s_dest  = dst;
  endtask

  logic [3:0] bp_exp [4];

  initial begin
    rst_n   = 1'b0;
    mode    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_dest  = '0;
    m_ready = '0;
    bp_exp[0] = 4'b0001;
    bp_exp[1] = 4'b0011;
    bp_exp[2] = 4'b0101;
    bp_exp[3] = 4'b1001;

    #2;
    chk("rst_valid", m_valid, 0);
    chk("rst_rr", rr_ptr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", m_data, 0);
    #10 rst_n = 1'b1;
    tick();

    // directed mode
    mode    = 1'b0;
    m_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(8'hA0 + 8'(i), 2'(i));
      @(negedge clk);
      chk("dir_rdy", s_ready, 1);
      tick();
      chk("dir_vld", m_valid, 32'(1 << i));
      chk("dir_dat", chd(i), 32'h A0 + i);
    end
    s_valid = 1'b0;
    chk("dir_rr", rr_ptr, 0);
    tick();
    chk("dir_idle", m_valid, 0);
    chk("dir_busy", busy, 0);

    // round-robin with wrap, s_dest deliberately misleading
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(8'h10 + 8'(i), 2'(3 - (i % 4)));
      @(negedge clk);
      chk("rr_rdy", s_ready, 1);
      tick();
      chk("rr_vld", m_valid, 32'(1 << (i % 4)));
      chk("rr_dat", chd(i % 4), 32'h10 + i);
    end
    s_valid = 1'b0;
    chk("rr_ptr_end", rr_ptr, 2);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(8'h16 + 8'(i), 2'd0);
      tick();
    end
    s_valid = 1'b0;
    tick();
    chk("rr_wrap0", rr_ptr, 0);
    chk("rr_empty", m_valid, 0);

    // backpressure on ch0, strict rotation
    m_ready = 4'b1110;
    for (int j = 0; j < 4; j++) begin
      drive(8'h20 + 8'(j), 2'd0);
      @(negedge clk);
      chk("bp_rdy", s_ready, 1);
      tick();
      chk("bp_vld", m_valid, 32'(bp_exp[j]));
      chk("bp_dat", chd(j), 32'h20 + j);
    end
    drive(8'h24, 2'd1);
    @(negedge clk);
    chk("bp_stall", s_ready, 0);
    tick();
    chk("bp_hold_vld", m_valid, 4'b0001);
    chk("bp_hold_dat", chd(0), 8'h20);
    chk("bp_hold_rr", rr_ptr, 0);
    @(negedge clk);
    chk("bp_stall2", s_ready, 0);
    m_ready = 4'b1111;
    #1;
    chk("bp_release", s_ready, 1);
    tick();
    chk("bp_new_vld", m_valid, 4'b0001);
    chk("bp_new_dat", chd(0), 8'h24);
    chk("bp_rr", rr_ptr, 1);
    s_valid = 1'b0;

    // same-cycle drain and write on ch2
    mode    = 1'b0;
    m_ready = 4'b1011;
    tick();
    chk("dw_empty", m_valid, 0);
    drive(8'h55, 2'd2);
    @(negedge clk);
    chk("dw_rdy0", s_ready, 1);
    tick();
    chk("dw_vld0", m_valid, 4'b0100);
    chk("dw_dat0", chd(2), 8'h55);
    m_ready = 4'b1111;
    drive(8'h66, 2'd2);
    @(negedge clk);
    chk("dw_rdy1", s_ready, 1);
    tick();
    chk("dw_vld1", m_valid, 4'b0100);
    chk("dw_dat1", chd(2), 8'h66);
    s_valid = 1'b0;
    tick();
    chk("dw_drained", m_valid, 0);
    chk("dw_keep", chd(2), 8'h66);
    chk("dw_rr_hold", rr_ptr, 1);

    // fill ch0 and ch2, then async reset between edges
    m_ready = 4'b0000;
    drive(8'h71, 2'd0);
    tick();
    drive(8'h72, 2'd2);
    tick();
    s_valid = 1'b0;
    chk("pre_rst_vld", m_valid, 4'b0101);
    chk("pre_rst_busy", busy, 1);
    drive(8'h73, 2'd0);
    #1;
    chk("dir_stall", s_ready, 0);
    s_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_vld", m_valid, 0);
    chk("arst_rr", rr_ptr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", m_data, 0);
    #3 rst_n = 1'b1;
    tick();
    mode    = 1'b1;
    m_ready = 4'b1111;
    drive(8'h80, 2'd3);
    @(negedge clk);
    chk("post_rdy", s_ready, 1);
    tick();
    chk("post_vld", m_valid, 4'b0001);
    chk("post_dat", chd(0), 8'h80);
    chk("post_rr", rr_ptr, 1);
    s_valid = 1'b0;
    tick();

    // ch1 blocked while rr_ptr=1
    mode    = 1'b0;
    m_ready = 4'b1101;
    drive(8'h90, 2'd1);
    tick();
    s_valid = 1'b0;
    chk("sk_fill", m_valid, 4'b0010);
    mode = 1'b1;
    drive(8'h91, 2'd0);
    #1;
`ifdef DEMUX_RR_SKIP_EN
    chk("sk_rdy", s_ready, 1);
    tick();
    chk("sk_vld", m_valid, 4'b0110);
    chk("sk_dat", chd(2), 8'h91);
    chk("sk_rr", rr_ptr, 3);
`else
    chk("strict_rdy", s_ready, 0);
    tick();
    chk("strict_vld", m_valid, 4'b0010);
    chk("strict_rr", rr_ptr, 1);
`endif
    s_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
